// File: rtl/scanline_pkg.sv
// Shared types and geometry for the scanline fetcher: FSM states, line and screen sizes,
// and the palette index type.
package scanline_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    typedef logic [4:0] pal_t;

    localparam int WORDS_PER_LINE = 160;
    localparam int H_LOGICAL      = 320;
    localparam int H_ACTIVE       = 640;
    localparam int V_ACTIVE       = 480;

endpackage

// File: rtl/scanline_line_buffer_dp.sv
// Two 320-entry palette-index line buffers packed into one 640x5 RAM.
// The write port stores an even/odd pixel pair per memory word; the read port is registered.
module line_buffer_dp
    import scanline_pkg::*;
(
    input  logic       clk,
    input  logic       wr_en,
    input  logic       wr_sel,
    input  logic [7:0] wr_pair,
    input  logic [4:0] wr_even,
    input  logic [4:0] wr_odd,
    input  logic       rd_sel,
    input  logic [8:0] rd_idx,
    output logic [4:0] rd_data
);

    localparam int DEPTH = 2 * H_LOGICAL;

    logic [4:0] mem [0:DEPTH-1];
    logic [9:0] wa_even;
    logic [9:0] wa_odd;
    logic [9:0] ra;
    logic [8:0] rd_idx_safe;

    assign wa_even = (wr_sel ? 10'(H_LOGICAL) : 10'd0) + {1'b0, wr_pair, 1'b0};
    assign wa_odd  = wa_even + 10'd1;

    // Columns past the logical line are blanked downstream; keep the read in range.
    assign rd_idx_safe = (rd_idx < 9'(H_LOGICAL)) ? rd_idx : 9'd0;
    assign ra          = (rd_sel ? 10'(H_LOGICAL) : 10'd0) + {1'b0, rd_idx_safe};

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wa_even] <= wr_even;
            mem[wa_odd]  <= wr_odd;
        end
        rd_data <= mem[ra];
    end

endmodule

// File: rtl/scanline_fetcher.sv
// Double-buffered scanline fetcher: fills one line buffer from memory during blanking while
// the other is displayed at 2x horizontal scale. Build option: SCANLINE_UNDERRUN_MARK_EN.
module scanline_fetcher
    import scanline_pkg::*;
#(
    parameter logic [19:0] FRAME_BASE     = 20'h00000,
    parameter int          WORDS_PER_LINE = scanline_pkg::WORDS_PER_LINE
)(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        new_line,
    input  logic [9:0]  fetch_y,
    output logic        mem_rd,
    output logic [19:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [4:0]  memMappedValue,
    output logic        underrun
);

    localparam int WORD_W = $clog2(WORDS_PER_LINE);

    state_t            state, state_nx;
    logic [WORD_W-1:0] word;
    logic [19:0]       base;
    logic              disp_sel;
    logic              start, abort, accept, last;
    logic              vld_p1;
    pal_t              pix_p1;
    logic              unused_bits;

    assign unused_bits = ^{fetch_y[0], mem_rdata[15:13], mem_rdata[7:5]};

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        abort    = 1'b0;
        accept   = 1'b0;
        last     = 1'b0;
        case (state)
            IDLE, DONE: begin
                state_nx = IDLE;
                if (new_line) begin
                    start    = 1'b1;
                    state_nx = FETCH;
                end
            end
            FETCH: begin
                // A new line outranks a same-cycle ack; the acked word is dropped.
                if (new_line) begin
                    abort = 1'b1;
                end else if (mem_ack) begin
                    accept = 1'b1;
                    if (word == WORD_W'(WORDS_PER_LINE - 1)) begin
                        last     = 1'b1;
                        state_nx = DONE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            word     <= '0;
            base     <= '0;
            disp_sel <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (start || abort) begin
                disp_sel <= ~disp_sel;
                word     <= '0;
                base     <= FRAME_BASE + 20'(fetch_y[9:1]) * 20'(WORDS_PER_LINE);
            end else if (accept && !last) begin
                word <= word + 1'b1;
            end
            if (abort) underrun <= 1'b1;
        end
    end

    assign mem_rd   = (state == FETCH);
    assign mem_addr = (state == FETCH) ? base + 20'(word) : 20'd0;

    line_buffer_dp u_buf (
        .clk     (Clk),
        .wr_en   (accept),
        .wr_sel  (~disp_sel),
        .wr_pair (8'(word)),
        .wr_even (mem_rdata[4:0]),
        .wr_odd  (mem_rdata[12:8]),
        .rd_sel  (disp_sel),
        .rd_idx  (DrawX[9:1]),
        .rd_data (pix_p1)
    );

    // ---- stage p1: blank mask registered alongside the buffer read ----
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) vld_p1 <= 1'b0;
        else       vld_p1 <= (DrawX < 10'(H_ACTIVE)) && (DrawY < 10'(V_ACTIVE));
    end

`ifdef SCANLINE_UNDERRUN_MARK_EN
    logic [1:0] bad;
    logic       bad_p1;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bad    <= 2'b00;
            bad_p1 <= 1'b0;
        end else begin
            if (abort)     bad[~disp_sel] <= 1'b1;
            else if (last) bad[~disp_sel] <= 1'b0;
            bad_p1 <= bad[disp_sel];
        end
    end

    assign memMappedValue = !vld_p1 ? 5'h00 : (bad_p1 ? 5'h01 : pix_p1);
`else
    assign memMappedValue = vld_p1 ? pix_p1 : 5'h00;
`endif

endmodule

// File: tb/tb_scanline_fetcher.sv
// Directed bench for scanline_fetcher: line fill, display readout and blanking, underrun abort,
// ack/new_line collision and asynchronous reset.
module tb_scanline_fetcher;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic        new_line = 1'b0;
    logic [9:0]  fetch_y = '0;
    logic        mem_rd;
    logic [19:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata;
    logic [4:0]  memMappedValue;
    logic        underrun;

    int n_chk = 0;
    int n_pass = 0;
    bit resp_en = 1'b0;
    bit force_ack = 1'b0;
    int ack_limit = 0;
    int n_ack = 0;
    int cyc_cnt = 0;
    int off = 0;
    logic [19:0] addr_log [0:511];

    always #5 Clk = ~Clk;

    scanline_fetcher dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .DrawX          (DrawX),
        .DrawY          (DrawY),
        .new_line       (new_line),
        .fetch_y        (fetch_y),
        .mem_rd         (mem_rd),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .memMappedValue (memMappedValue),
        .underrun       (underrun)
    );

    // Word k of a line holds pixel pair (k+off, k+1+off).
    always_comb begin
        int k;
        k = int'(mem_addr % 20'd160);
        mem_rdata = {3'b000, 5'(k + 1 + off), 3'b000, 5'(k + off)};
    end

    // Memory responder: ack every 3rd cycle of an active request, up to ack_limit acks.
    always @(negedge Clk) begin
        cyc_cnt = mem_rd ? cyc_cnt + 1 : 0;
        if (force_ack) begin
            mem_ack = 1'b1;
        end else if (resp_en && mem_rd && (cyc_cnt % 3 == 0) && (n_ack < ack_limit)) begin
            mem_ack = 1'b1;
            if (n_ack < 512) addr_log[n_ack] = mem_addr;
            n_ack++;
        end else begin
            mem_ack = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic pix(input int x, input int y, input int exp, input string tag);
        DrawX = 10'(x);
        DrawY = 10'(y);
        step();
        chk(tag, 32'(memMappedValue), 32'(exp));
    endtask

    initial begin
        int errs;
        step(3);
        chk("rst_mem_rd", 32'(mem_rd), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_underrun", 32'(underrun), 0);
        chk("rst_pixel", 32'(memMappedValue), 0);
        Reset = 1'b0;
        step(2);

        // Full line fill for fetch_y=10 -> addresses 800..959
        off = 0; resp_en = 1'b1; ack_limit = 160; fetch_y = 10'd10;
        new_line = 1'b1; step(); new_line = 1'b0;
        chk("fetch_start_rd", 32'(mem_rd), 1);
        chk("fetch_start_addr", 32'(mem_addr), 800);
        for (int i = 0; i < 1500 && !(n_ack >= 160 && !mem_rd); i++) step();
        chk("req_count", 32'(n_ack), 160);
        chk("first_addr", 32'(addr_log[0]), 800);
        chk("last_addr", 32'(addr_log[159]), 959);
        errs = 0;
        for (int i = 0; i < 160; i++) if (addr_log[i] !== 20'(800 + i)) errs++;
        chk("addr_order", 32'(errs), 0);
        step(5);
        chk("idle_mem_rd", 32'(mem_rd), 0);
        chk("no_extra_req", 32'(n_ack), 160);

        // Swap the filled buffer onto the display; next fetch is left stalled
        resp_en = 1'b0; off = 8; fetch_y = 10'd10;
        new_line = 1'b1; step(); new_line = 1'b0;
        pix(2, 0, 1, "px_x2");
        pix(0, 0, 0, "px_x0");
        pix(1, 0, 0, "px_x1");
        pix(203, 100, 19, "px_x203");
        pix(637, 0, 31, "px_x637");
        pix(300, 479, 11, "px_x300");
        DrawX = 10'd2; DrawY = 10'd0;
        #1 chk("latency_hold", 32'(memMappedValue), 11);
        step();
        chk("latency_new", 32'(memMappedValue), 1);
        pix(700, 10, 0, "blank_x700");
        pix(2, 490, 0, "blank_y490");

        // Abort the fetch after 50 words
        chk("underrun_pre", 32'(underrun), 0);
        ack_limit = n_ack + 50; resp_en = 1'b1;
        for (int i = 0; i < 1000 && n_ack < ack_limit; i++) step();
        chk("partial_acks", 32'(n_ack), 210);
        resp_en = 1'b0; fetch_y = 10'd20;
        new_line = 1'b1; step(); new_line = 1'b0;
        chk("underrun_set", 32'(underrun), 1);
        chk("restart_rd", 32'(mem_rd), 1);
        chk("restart_addr", 32'(mem_addr), 1600);
`ifdef SCANLINE_UNDERRUN_MARK_EN
        pix(2, 0, 1, "bad_x2");
        pix(40, 0, 1, "bad_x40");
        pix(300, 200, 1, "bad_x300");
`else
        pix(2, 0, 9, "stale_x2");
        pix(40, 0, 18, "stale_x40");
`endif
        pix(700, 0, 0, "bad_blank");
        step(3);
        chk("restart_hold_addr", 32'(mem_addr), 1600);

        // ack and new_line in the same cycle
        off = 20; fetch_y = 10'd30; force_ack = 1'b1;
        new_line = 1'b1; step(); new_line = 1'b0; force_ack = 1'b0;
        chk("coinc_addr", 32'(mem_addr), 2400);
        chk("coinc_underrun", 32'(underrun), 1);
`ifdef SCANLINE_UNDERRUN_MARK_EN
        pix(0, 0, 1, "coinc_x0");
        pix(40, 0, 1, "coinc_x40");
`else
        pix(0, 0, 0, "coinc_x0");
        pix(40, 0, 10, "coinc_x40");
`endif
        pix(2, 0, 1, "coinc_x2");

        // Asynchronous reset mid-fetch
        chk("pre_reset_rd", 32'(mem_rd), 1);
        #3 Reset = 1'b1;
        #1;
        chk("async_rst_rd", 32'(mem_rd), 0);
        chk("async_rst_addr", 32'(mem_addr), 0);
        chk("async_rst_pixel", 32'(memMappedValue), 0);
        chk("async_rst_underrun", 32'(underrun), 0);
        step();
        Reset = 1'b0;
        step(2);
        chk("post_rst_rd", 32'(mem_rd), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
